// File: rtl/cv32e40p_ft_pkg.sv
// rtl/cv32e40p_ft_pkg.sv - shared types and helpers for the fault-tolerant dispatcher
package cv32e40p_ft_pkg;

   localparam int FT_IDX_MAX_W = 8;
   localparam int FT_MAX_UNITS = 64;

   typedef enum logic [1:0] {
      FT_TMR    = 2'b00,
      FT_DMR    = 2'b01,
      FT_SINGLE = 2'b10,
      FT_DEAD   = 2'b11
   } ft_mode_e;

   typedef struct packed {
      logic [FT_IDX_MAX_W-1:0] slot2;
      logic [FT_IDX_MAX_W-1:0] slot1;
      logic [FT_IDX_MAX_W-1:0] slot0;
      ft_mode_e                mode;
   } ft_cfg_t;

   function automatic int unsigned popcount_healthy(input logic [FT_MAX_UNITS-1:0] faulty,
                                                    input int unsigned num_units);
      int unsigned cnt;
      cnt = 0;
      for (int i = 0; i < FT_MAX_UNITS; i++) begin
         if ((i < int'(num_units)) && !faulty[i]) cnt++;
      end
      return cnt;
   endfunction

   function automatic ft_cfg_t ft_cfg_reset();
      ft_cfg_t cfg;
      cfg.slot0 = FT_IDX_MAX_W'(0);
      cfg.slot1 = FT_IDX_MAX_W'(1);
      cfg.slot2 = FT_IDX_MAX_W'(2);
      cfg.mode  = FT_TMR;
      return cfg;
   endfunction

endpackage

// File: rtl/cv32e40p_ft_unit_selector.sv
// rtl/cv32e40p_ft_unit_selector.sv - maps a faulty mask to the lowest healthy voting slots and mode
module cv32e40p_ft_unit_selector
   import cv32e40p_ft_pkg::*;
#(
   parameter int NUM_UNITS = 4
) (
   input  logic [NUM_UNITS-1:0] faulty_i,
   output ft_cfg_t              cfg_o
);

   logic [FT_MAX_UNITS-1:0] faulty_ext;
   int unsigned             healthy;
   logic [FT_IDX_MAX_W-1:0] s0, s1, s2;

   always_comb begin
      int found;
      faulty_ext = FT_MAX_UNITS'(faulty_i);
      healthy    = popcount_healthy(faulty_ext, NUM_UNITS);
      s0 = '0;
      s1 = '0;
      s2 = '0;
      found = 0;
      for (int u = 0; u < NUM_UNITS; u++) begin
         if (!faulty_i[u]) begin
            if (found == 0)      s0 = FT_IDX_MAX_W'(u);
            else if (found == 1) s1 = FT_IDX_MAX_W'(u);
            else if (found == 2) s2 = FT_IDX_MAX_W'(u);
            found++;
         end
      end
      cfg_o.slot0 = s0;
      cfg_o.slot1 = s1;
      cfg_o.slot2 = s2;
      cfg_o.mode  = FT_TMR;
      // Degraded modes replicate the last healthy slot into the empty ones
      if (healthy == 2) begin
         cfg_o.slot2 = s1;
         cfg_o.mode  = FT_DMR;
      end else if (healthy == 1) begin
         cfg_o.slot1 = s0;
         cfg_o.slot2 = s0;
         cfg_o.mode  = FT_SINGLE;
      end else if (healthy == 0) begin
         cfg_o.slot0 = '0;
         cfg_o.slot1 = '0;
         cfg_o.slot2 = '0;
         cfg_o.mode  = FT_DEAD;
      end
   end

endmodule

// File: rtl/cv32e40p_dispatcher_ft_param.sv
// rtl/cv32e40p_dispatcher_ft_param.sv - leaky-bucket fault tracking and replica selection per unit class
module cv32e40p_dispatcher_ft_param
   import cv32e40p_ft_pkg::*;
#(
   parameter int NUM_UNITS   = 4,
   parameter int NUM_CLASSES = 2,
   parameter int ERR_THRESH  = 8,
   parameter int IDX_W       = $clog2(NUM_UNITS),
   parameter int CNT_W       = $clog2(ERR_THRESH + 1),
   parameter int CLS_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_CLASSES-1:0]             class_sel_i,
   input  logic                               err_valid_i,
   input  logic [CLS_W-1:0]                   err_class_i,
   input  logic [NUM_UNITS-1:0]               err_vec_i,
   input  logic                               fault_clear_i,
   input  logic                               reconfig_ack_i,
   output logic                               reconfig_req_o,
   output logic [NUM_UNITS-1:0]               clock_gate_o,
   output logic [3*IDX_W-1:0]                 sel_idx_o,
   output logic [1:0]                         mode_o,
   output logic [NUM_CLASSES*NUM_UNITS-1:0]   faulty_mask_o,
   output logic [NUM_CLASSES-1:0]             totally_defective_o
);

   logic [CNT_W-1:0]                        cnt_q [NUM_CLASSES][NUM_UNITS];
   logic [CNT_W-1:0]                        cnt_d [NUM_CLASSES][NUM_UNITS];
   logic [NUM_CLASSES-1:0][NUM_UNITS-1:0]   faulty_q, faulty_d;
   ft_cfg_t                                 app_q [NUM_CLASSES];
   ft_cfg_t                                 app_d [NUM_CLASSES];
   ft_cfg_t                                 pend  [NUM_CLASSES];
   ft_cfg_t                                 out_cfg;
   logic                                    req;
   logic                                    sel_onehot;

   function automatic logic in_active_set(input ft_cfg_t cfg, input int u);
      return (cfg.mode != FT_DEAD) &&
             ((cfg.slot0 == FT_IDX_MAX_W'(u)) || (cfg.slot1 == FT_IDX_MAX_W'(u)) ||
              (cfg.slot2 == FT_IDX_MAX_W'(u)));
   endfunction

   for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_sel
      cv32e40p_ft_unit_selector #(.NUM_UNITS(NUM_UNITS)) u_selector (
         .faulty_i (faulty_q[c]),
         .cfg_o    (pend[c])
      );
   end

   always_comb begin
      cnt_d    = cnt_q;
      faulty_d = faulty_q;
      for (int c = 0; c < NUM_CLASSES; c++) begin
         for (int u = 0; u < NUM_UNITS; u++) begin
            if (err_valid_i && (int'(err_class_i) == c)) begin
               if (err_vec_i[u]) begin
                  if (cnt_q[c][u] != CNT_W'(ERR_THRESH)) cnt_d[c][u] = cnt_q[c][u] + 1'b1;
               end else if (in_active_set(app_q[c], u) && (cnt_q[c][u] != '0)) begin
                  cnt_d[c][u] = cnt_q[c][u] - 1'b1;
               end
            end
            if (cnt_d[c][u] == CNT_W'(ERR_THRESH)) faulty_d[c][u] = 1'b1;
            if (fault_clear_i) begin
               cnt_d[c][u]    = '0;
               faulty_d[c][u] = 1'b0;
            end
         end
      end
   end

   // Applied configuration doubles as the per-class mode state; it only moves on an acked request
   always_comb begin
      req   = 1'b0;
      app_d = app_q;
      for (int c = 0; c < NUM_CLASSES; c++) begin
         if (pend[c] != app_q[c]) req = 1'b1;
      end
      if (req && reconfig_ack_i) app_d = pend;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < NUM_CLASSES; c++) begin
            for (int u = 0; u < NUM_UNITS; u++) cnt_q[c][u] <= '0;
            app_q[c] <= ft_cfg_reset();
         end
         faulty_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         faulty_q <= faulty_d;
         app_q    <= app_d;
      end
   end

   always_comb begin
      out_cfg      = '0;
      clock_gate_o = '0;
      sel_onehot   = (class_sel_i != '0) && ((class_sel_i & (class_sel_i - 1'b1)) == '0);
      for (int c = 0; c < NUM_CLASSES; c++) begin
         if (sel_onehot && class_sel_i[c]) out_cfg = app_q[c];
      end
      if (sel_onehot && (out_cfg.mode != FT_DEAD)) begin
         clock_gate_o[int'(out_cfg.slot0)] = 1'b1;
         clock_gate_o[int'(out_cfg.slot1)] = 1'b1;
         clock_gate_o[int'(out_cfg.slot2)] = 1'b1;
      end
      sel_idx_o = {IDX_W'(out_cfg.slot2), IDX_W'(out_cfg.slot1), IDX_W'(out_cfg.slot0)};
      mode_o    = out_cfg.mode;
   end

   always_comb begin
      for (int c = 0; c < NUM_CLASSES; c++) totally_defective_o[c] = (app_q[c].mode == FT_DEAD);
   end

   assign reconfig_req_o = req;
   assign faulty_mask_o  = faulty_q;

endmodule

// File: tb/tb_cv32e40p_dispatcher_ft_param.sv
// tb/tb_cv32e40p_dispatcher_ft_param.sv - directed self-checking bench for the FT dispatcher
module tb_cv32e40p_dispatcher_ft_param;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] class_sel;
   logic       err_valid;
   logic       err_class;
   logic [3:0] err_vec;
   logic       fault_clear;
   logic       ack;
   logic       req;
   logic [3:0] cg;
   logic [5:0] sel_idx;
   logic [1:0] mode;
   logic [7:0] fmask;
   logic [1:0] tdef;

   int checks = 0;
   int passed = 0;

   cv32e40p_dispatcher_ft_param dut (
      .clk                 (clk),
      .rst                 (rst),
      .class_sel_i         (class_sel),
      .err_valid_i         (err_valid),
      .err_class_i         (err_class),
      .err_vec_i           (err_vec),
      .fault_clear_i       (fault_clear),
      .reconfig_ack_i      (ack),
      .reconfig_req_o      (req),
      .clock_gate_o        (cg),
      .sel_idx_o           (sel_idx),
      .mode_o              (mode),
      .faulty_mask_o       (fmask),
      .totally_defective_o (tdef)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic errs(input logic cls, input logic [3:0] vec, input int n);
      err_valid = 1'b1;
      err_class = cls;
      err_vec   = vec;
      repeat (n) tick();
      err_valid = 1'b0;
      err_vec   = 4'b0000;
   endtask

   task automatic chk_out(input string tag, input logic [3:0] e_cg, input logic [5:0] e_sel,
                          input logic [1:0] e_mode);
      chk({tag, "_cg"}, 16'(cg), 16'(e_cg));
      chk({tag, "_sel"}, 16'(sel_idx), 16'(e_sel));
      chk({tag, "_mode"}, 16'(mode), 16'(e_mode));
   endtask

   initial begin
      rst = 1'b1; class_sel = 2'b00; err_valid = 1'b0; err_class = 1'b0;
      err_vec = 4'b0000; fault_clear = 1'b0; ack = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      tick();

      // reset state, idle select
      chk_out("idle", 4'b0000, 6'h00, 2'b00);
      chk("rst_req", 16'(req), 16'd0);
      chk("rst_fmask", 16'(fmask), 16'h00);
      chk("rst_tdef", 16'(tdef), 16'd0);
      class_sel = 2'b11;
      #1 chk_out("not_onehot", 4'b0000, 6'h00, 2'b00);
      class_sel = 2'b01;
      #1 chk_out("alu_reset", 4'b0111, 6'h24, 2'b00);

      // threshold on ALU replica 1
      errs(1'b0, 4'b0010, 7);
      chk("thr7_fmask", 16'(fmask), 16'h00);
      chk("thr7_req", 16'(req), 16'd0);
      errs(1'b0, 4'b0010, 1);
      chk("thr8_fmask", 16'(fmask), 16'h02);
      chk("thr8_req", 16'(req), 16'd1);
      tick();
      chk_out("pre_ack", 4'b0111, 6'h24, 2'b00);
      ack = 1'b1; tick(); ack = 1'b0;
      chk_out("post_ack", 4'b1101, 6'h38, 2'b00);
      chk("post_ack_req", 16'(req), 16'd0);

      // leaky bucket on replica 2
      for (int i = 0; i < 40; i++) errs(1'b0, (i % 2 == 0) ? 4'b0100 : 4'b0000, 1);
      chk("leaky_fmask", 16'(fmask), 16'h02);
      chk("leaky_req", 16'(req), 16'd0);

      // MULT degradation with ack held high
      ack = 1'b1;
      class_sel = 2'b10;
      errs(1'b1, 4'b0111, 8);
      chk("mult3_fmask", 16'(fmask), 16'h72);
      chk("mult3_req", 16'(req), 16'd1);
      tick();
      chk_out("mult_single", 4'b1000, 6'h3F, 2'b10);
      chk("mult_single_req", 16'(req), 16'd0);
      errs(1'b1, 4'b1000, 8);
      chk("mult4_fmask", 16'(fmask), 16'hF2);
      tick();
      chk_out("mult_dead", 4'b0000, 6'h00, 2'b11);
      chk("mult_dead_tdef", 16'(tdef), 16'b10);
      ack = 1'b0;

      // second ALU fault while a request is pending
      class_sel = 2'b01;
      errs(1'b0, 4'b0001, 8);
      chk("pend1_req", 16'(req), 16'd1);
      repeat (5) tick();
      chk("pend5_req", 16'(req), 16'd1);
      errs(1'b0, 4'b1000, 8);
      chk("pend2_fmask", 16'(fmask), 16'hF3 | 16'h08);
      chk("pend2_req", 16'(req), 16'd1);
      chk_out("pend2_old", 4'b1101, 6'h38, 2'b00);
      ack = 1'b1; tick(); ack = 1'b0;
      chk_out("pend2_applied", 4'b0100, 6'h2A, 2'b10);
      chk("pend2_applied_req", 16'(req), 16'd0);

      // clear coinciding with a threshold-reaching error
      errs(1'b0, 4'b0100, 7);
      chk("pre_clr_fmask", 16'(fmask), 16'hFB);
      err_valid = 1'b1; err_class = 1'b0; err_vec = 4'b0100; fault_clear = 1'b1;
      tick();
      err_valid = 1'b0; err_vec = 4'b0000; fault_clear = 1'b0;
      chk("clr_fmask", 16'(fmask), 16'h00);
      chk("clr_req", 16'(req), 16'd1);
      chk("clr_tdef", 16'(tdef), 16'b10);
      ack = 1'b1; tick(); ack = 1'b0;
      chk_out("clr_alu", 4'b0111, 6'h24, 2'b00);
      chk("clr_tdef_after", 16'(tdef), 16'b00);
      chk("clr_req_after", 16'(req), 16'd0);
      class_sel = 2'b10;
      #1 chk_out("clr_mult", 4'b0111, 6'h24, 2'b00);
      class_sel = 2'b01;

      // ack without request is ignored
      ack = 1'b1; tick(); ack = 1'b0;
      chk("stray_ack_req", 16'(req), 16'd0);
      chk_out("stray_ack", 4'b0111, 6'h24, 2'b00);

      // clear that restores the applied configuration drops the request
      errs(1'b0, 4'b0010, 8);
      chk("restore_req", 16'(req), 16'd1);
      fault_clear = 1'b1; tick(); fault_clear = 1'b0;
      chk("restore_req_drop", 16'(req), 16'd0);
      chk("restore_fmask", 16'(fmask), 16'h00);

      // reset while a request is pending
      errs(1'b0, 4'b0001, 8);
      chk("rst_pend_req", 16'(req), 16'd1);
      chk("rst_pend_fmask", 16'(fmask), 16'h01);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rst_mid_req", 16'(req), 16'd0);
      chk("rst_mid_fmask", 16'(fmask), 16'h00);
      chk_out("rst_mid", 4'b0111, 6'h24, 2'b00);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
